// File: rtl/wb_regfile_stage.sv
// Y86-64 writeback stage: W pipeline register, register file with E/M write ports,
// bypassed decode read ports, sticky halt on exception status and retired-instruction counter.
module wb_regfile_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            W_stall,
  input  logic                            W_bubble,
  input  logic [3:0]                      m_icode,
  input  logic [1:0]                      m_stat,
  input  logic [DATA_W-1:0]               m_valE,
  input  logic [DATA_W-1:0]               m_valM,
  input  logic [ADDR_W-1:0]               m_dstE,
  input  logic [ADDR_W-1:0]               m_dstM,
  input  logic [ADDR_W-1:0]               srcA,
  input  logic [ADDR_W-1:0]               srcB,
  output logic [DATA_W-1:0]               valA,
  output logic [DATA_W-1:0]               valB,
  output logic [1:0]                      w_stat,
  output logic                            halted,
  output logic [CNT_W-1:0]                retire_cnt,
  output logic [(2**ADDR_W-1)*DATA_W-1:0] reg_dump
);

  localparam int NREG = 2**ADDR_W - 1;
  localparam logic [ADDR_W-1:0] RNONE = '1;
  localparam logic [1:0] STAT_AOK = 2'b00;

  logic [3:0]        w_icode;
  logic [DATA_W-1:0] w_val_e;
  logic [DATA_W-1:0] w_val_m;
  logic [ADDR_W-1:0] w_dst_e;
  logic [ADDR_W-1:0] w_dst_m;
  logic [DATA_W-1:0] regs [NREG];
  logic              commit_ok;

  // A non-AOK status in W freezes the stage from that point on, W included,
  // so w_stat keeps reporting the exception that stopped the machine.
  assign commit_ok = !halted && (w_stat == STAT_AOK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_icode <= 4'h0;
      w_stat  <= STAT_AOK;
      w_val_e <= '0;
      w_val_m <= '0;
      w_dst_e <= RNONE;
      w_dst_m <= RNONE;
    end else if (commit_ok && !W_stall) begin
      if (W_bubble) begin
        w_icode <= 4'h0;
        w_stat  <= STAT_AOK;
        w_val_e <= '0;
        w_val_m <= '0;
        w_dst_e <= RNONE;
        w_dst_m <= RNONE;
      end else begin
        w_icode <= m_icode;
        w_stat  <= m_stat;
        w_val_e <= m_valE;
        w_val_m <= m_valM;
        w_dst_e <= m_dstE;
        w_dst_m <= m_dstM;
      end
    end
  end

  // M port is written last so it wins when both ports target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit_ok) begin
      if (w_dst_e != RNONE) regs[w_dst_e] <= w_val_e;
      if (w_dst_m != RNONE) regs[w_dst_m] <= w_val_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (!halted && (w_stat != STAT_AOK)) halted <= 1'b1;
      if (commit_ok && (w_icode != 4'h0) && !W_stall)
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] src);
    logic [DATA_W-1:0] result;
    result = '0;
    if (src != RNONE) begin
      if (commit_ok && (w_dst_m == src))      result = w_val_m;
      else if (commit_ok && (w_dst_e == src)) result = w_val_e;
      else                                    result = regs[src];
    end
    return result;
  endfunction

  always_comb begin
    valA = read_port(srcA);
    valB = read_port(srcB);
  end

  for (genvar g = 0; g < NREG; g++) begin : g_dump
    assign reg_dump[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed self-checking bench for wb_regfile_stage (CNT_W=3 so the counter wrap is reachable).
module tb_wb_regfile_stage;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 3;
  localparam int NREG   = 15;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [1:0] AOK = 2'b00, HLT = 2'b01;

  logic                   clk, rst_n, W_stall, W_bubble;
  logic [3:0]             m_icode;
  logic [1:0]             m_stat;
  logic [DATA_W-1:0]      m_valE, m_valM;
  logic [ADDR_W-1:0]      m_dstE, m_dstM, srcA, srcB;
  logic [DATA_W-1:0]      valA, valB;
  logic [1:0]             w_stat;
  logic                   halted;
  logic [CNT_W-1:0]       retire_cnt;
  logic [NREG*DATA_W-1:0] reg_dump;

  int checks = 0;
  int errors = 0;

  wb_regfile_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_icode(m_icode), .m_stat(m_stat), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .w_stat(w_stat), .halted(halted),
    .retire_cnt(retire_cnt), .reg_dump(reg_dump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] icode, input logic [1:0] stat,
                               input logic [63:0] ve, input logic [63:0] vm,
                               input logic [3:0] de, input logic [3:0] dm);
    m_icode = icode;
    m_stat  = stat;
    m_valE  = ve;
    m_valM  = vm;
    m_dstE  = de;
    m_dstM  = dm;
  endtask

  task automatic applyNop();
    applyStimulus(4'h0, AOK, 64'd0, 64'd0, RNONE, RNONE);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] getReg(input int idx);
    return reg_dump[idx*DATA_W +: DATA_W];
  endfunction

  initial begin
    rst_n = 1'b0;
    W_stall = 1'b0;
    W_bubble = 1'b0;
    srcA = RNONE;
    srcB = RNONE;
    applyNop();
    #12;
    checkOutput("reset_halted", 64'(halted), 64'd0);
    checkOutput("reset_retire", 64'(retire_cnt), 64'd0);
    checkOutput("reset_wstat", 64'(w_stat), 64'd0);
    checkOutput("reset_dump_nonzero", 64'(|reg_dump), 64'd0);
    checkOutput("reset_valA_rnone", valA, 64'd0);
    rst_n = 1'b1;

    // Simple E-port write with bypass one edge before commit
    applyStimulus(4'h3, AOK, 64'd102, 64'd0, 4'd2, RNONE);
    srcA = 4'd2;
    step();
    checkOutput("bypass_valA_r2", valA, 64'd102);
    checkOutput("r2_before_commit", getReg(2), 64'd0);
    applyNop();
    step();
    checkOutput("r2_commit", getReg(2), 64'd102);
    checkOutput("retire_after_1", 64'(retire_cnt), 64'd1);
    checkOutput("valA_r2_committed", valA, 64'd102);

    // Same destination on both ports: M wins
    applyStimulus(4'hB, AOK, 64'd200, 64'd55, 4'd4, 4'd4);
    srcA = 4'd4;
    step();
    checkOutput("bypass_m_over_e", valA, 64'd55);
    applyNop();
    step();
    checkOutput("r4_m_priority", getReg(4), 64'd55);

    // Distinct destinations written at the same edge
    applyStimulus(4'hB, AOK, 64'd200, 64'd87, 4'd4, 4'd9);
    srcB = 4'd9;
    step();
    checkOutput("bypass_e_r4", valA, 64'd200);
    checkOutput("bypass_m_r9", valB, 64'd87);
    applyNop();
    step();
    checkOutput("r4_dual", getReg(4), 64'd200);
    checkOutput("r9_dual", getReg(9), 64'd87);
    checkOutput("retire_after_3", 64'(retire_cnt), 64'd3);

    // Bubble discards the incoming instruction
    applyStimulus(4'h3, AOK, 64'd7, 64'd0, 4'd1, RNONE);
    W_bubble = 1'b1;
    srcA = 4'd1;
    step();
    checkOutput("bubble_wstat", 64'(w_stat), 64'd0);
    checkOutput("bubble_no_bypass", valA, 64'd0);
    W_bubble = 1'b0;
    applyNop();
    step();
    checkOutput("bubble_r1", getReg(1), 64'd0);
    checkOutput("bubble_retire", 64'(retire_cnt), 64'd3);

    // Stall beats bubble: held instruction rewrites, counts once on release
    applyStimulus(4'h3, AOK, 64'd11, 64'd0, 4'd6, RNONE);
    step();
    W_stall = 1'b1;
    W_bubble = 1'b1;
    applyNop();
    step();
    checkOutput("stall_r6_written", getReg(6), 64'd11);
    checkOutput("stall_retire_held", 64'(retire_cnt), 64'd3);
    step();
    checkOutput("stall_retire_held2", 64'(retire_cnt), 64'd3);
    W_stall = 1'b0;
    W_bubble = 1'b0;
    step();
    checkOutput("stall_release_retire", 64'(retire_cnt), 64'd4);
    step();
    checkOutput("stall_counted_once", 64'(retire_cnt), 64'd4);

    // Halt on HLT status; nothing commits afterwards
    applyStimulus(4'h3, HLT, 64'd5, 64'd0, 4'd3, RNONE);
    step();
    checkOutput("hlt_captured_wstat", 64'(w_stat), 64'd1);
    checkOutput("hlt_not_yet_halted", 64'(halted), 64'd0);
    applyStimulus(4'h3, AOK, 64'd77, 64'd0, 4'd7, RNONE);
    step();
    checkOutput("halted_set", 64'(halted), 64'd1);
    checkOutput("hlt_r3_unwritten", getReg(3), 64'd0);
    checkOutput("hlt_wstat_kept", 64'(w_stat), 64'd1);
    applyStimulus(4'h3, AOK, 64'd88, 64'd0, 4'd8, RNONE);
    step();
    step();
    checkOutput("frozen_r7", getReg(7), 64'd0);
    checkOutput("frozen_r8", getReg(8), 64'd0);
    checkOutput("frozen_retire", 64'(retire_cnt), 64'd4);
    checkOutput("frozen_wstat", 64'(w_stat), 64'd1);
    checkOutput("frozen_r6", getReg(6), 64'd11);

    // Asynchronous reset between edges clears halt and state immediately
    rst_n = 1'b0;
    #2;
    checkOutput("areset_halted", 64'(halted), 64'd0);
    checkOutput("areset_wstat", 64'(w_stat), 64'd0);
    checkOutput("areset_retire", 64'(retire_cnt), 64'd0);
    checkOutput("areset_dump_nonzero", 64'(|reg_dump), 64'd0);
    rst_n = 1'b1;
    applyStimulus(4'h3, AOK, 64'd9, 64'd0, 4'd5, RNONE);
    step();
    applyNop();
    step();
    checkOutput("post_reset_r5", getReg(5), 64'd9);
    checkOutput("post_reset_retire", 64'(retire_cnt), 64'd1);

    // Counter wrap: 9 back-to-back irmovq after a fresh reset
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(4'h3, AOK, 64'(k), 64'd0, 4'd10, RNONE);
      step();
      if (k == 8) checkOutput("wrap_cnt_7", 64'(retire_cnt), 64'd7);
      if (k == 9) checkOutput("wrap_cnt_0", 64'(retire_cnt), 64'd0);
    end
    applyNop();
    step();
    checkOutput("wrap_cnt_1", 64'(retire_cnt), 64'd1);
    checkOutput("wrap_r10", getReg(10), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
